// File: rtl/out_xor_signature.sv
// Folds each output channel to DOUT_WIDTH bits, XOR-reduces the channels through a
// registered binary tree, and builds a per-run signature and word count bounded by ap_start/ap_done.
module out_xor_signature #(
    parameter int CH_NUM     = 4,
    parameter int DIN_WIDTH  = 32,
    parameter int DOUT_WIDTH = 4,
    parameter int SIG_WIDTH  = 32,
    parameter int CNT_WIDTH  = 24
) (
    input  logic                           ap_clk,
    input  logic                           ap_rst_n,
    input  logic                           ap_start,
    input  logic                           ap_done,
    input  logic [CH_NUM-1:0]              ch_write,
    input  logic [CH_NUM*DIN_WIDTH-1:0]    ch_din,
    output logic [DOUT_WIDTH-1:0]          data_out,
    output logic                           data_valid,
    output logic [SIG_WIDTH-1:0]           sig_out,
    output logic [CNT_WIDTH-1:0]           word_cnt,
    output logic                           sig_valid,
    output logic                           busy
);
    localparam int LVL    = $clog2(CH_NUM);
    localparam int CHUNKS = DIN_WIDTH / DOUT_WIDTH;
    localparam int NODES  = 2 * CH_NUM - 1;
    localparam int LAT    = LVL + 2;
    localparam int DW     = $clog2(LAT + 1);
    localparam int PCW    = $clog2(CH_NUM + 1);
    localparam int CW1    = CNT_WIDTH + 1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, REPORT} state_t;

    state_t               state, state_next;
    logic                 ap_start_q;
    logic                 start_edge;
    logic                 acc_en;
    logic                 clear_run;
    logic                 load_drain;
    logic                 fire;
    logic [DW-1:0]        drain_cnt;
    logic                 out_tag;

    logic [DOUT_WIDTH-1:0] fold [CH_NUM];
    // Heap-ordered tree: node n has children 2n+1 and 2n+2; leaves hold the folded channels.
    logic [DOUT_WIDTH-1:0] node_val [NODES];
    logic                  node_vld [NODES];
    logic                  node_tag [NODES];

    logic [PCW-1:0]        pop;
    logic [CW1-1:0]        cnt_sum;
    logic [CNT_WIDTH-1:0]  cnt_sat;
    logic [SIG_WIDTH-1:0]  sig_next;

    always_comb begin
        for (int i = 0; i < CH_NUM; i++) begin
            fold[i] = '0;
            for (int c = 0; c < CHUNKS; c++) begin
                fold[i] = fold[i] ^ ch_din[i*DIN_WIDTH + c*DOUT_WIDTH +: DOUT_WIDTH];
            end
        end
    end

    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            for (int n = 0; n < NODES; n++) begin
                node_val[n] <= '0;
                node_vld[n] <= 1'b0;
                node_tag[n] <= 1'b0;
            end
            data_out   <= '0;
            data_valid <= 1'b0;
            out_tag    <= 1'b0;
        end else begin
            for (int i = 0; i < CH_NUM; i++) begin
                node_val[CH_NUM-1+i] <= fold[i];
                node_vld[CH_NUM-1+i] <= ch_write[i];
                node_tag[CH_NUM-1+i] <= acc_en;
            end
            for (int n = 0; n < CH_NUM - 1; n++) begin
                node_val[n] <= (node_vld[2*n+1] ? node_val[2*n+1] : '0)
                             ^ (node_vld[2*n+2] ? node_val[2*n+2] : '0);
                node_vld[n] <= node_vld[2*n+1] | node_vld[2*n+2];
                node_tag[n] <= (node_vld[2*n+1] & node_tag[2*n+1])
                             | (node_vld[2*n+2] & node_tag[2*n+2]);
            end
            data_out   <= node_val[0];
            data_valid <= node_vld[0];
            out_tag    <= node_tag[0];
        end
    end

    always_comb begin
        pop = '0;
        for (int i = 0; i < CH_NUM; i++) begin
            pop = pop + PCW'(ch_write[i]);
        end
        cnt_sum  = {1'b0, word_cnt} + CW1'(pop);
        cnt_sat  = cnt_sum[CNT_WIDTH] ? '1 : cnt_sum[CNT_WIDTH-1:0];
        sig_next = {sig_out[SIG_WIDTH-2:0], sig_out[SIG_WIDTH-1]} ^ SIG_WIDTH'(data_out);
    end

    assign start_edge = ap_start & ~ap_start_q;
    assign busy       = (state == RUN) | (state == DRAIN);

    always_comb begin
        state_next = state;
        acc_en     = 1'b0;
        clear_run  = 1'b0;
        load_drain = 1'b0;
        fire       = 1'b0;
        case (state)
            IDLE, REPORT: begin
                if (start_edge) begin
                    clear_run  = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                acc_en = 1'b1;
                if (ap_done) begin
                    load_drain = 1'b1;
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                // Waits out the pipeline so the last tagged word is folded in before reporting.
                if (drain_cnt == '0) begin
                    fire       = 1'b1;
                    state_next = REPORT;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            state      <= IDLE;
            ap_start_q <= 1'b0;
            drain_cnt  <= '0;
            sig_out    <= '0;
            word_cnt   <= '0;
            sig_valid  <= 1'b0;
        end else begin
            state      <= state_next;
            ap_start_q <= ap_start;
            sig_valid  <= fire;
            if (load_drain) begin
                drain_cnt <= DW'(LAT);
            end else if (state == DRAIN && drain_cnt != '0) begin
                drain_cnt <= drain_cnt - 1'b1;
            end
            if (clear_run) begin
                sig_out  <= '0;
                word_cnt <= '0;
            end else begin
                if (acc_en) begin
                    word_cnt <= cnt_sat;
                end
                if (data_valid && out_tag) begin
                    sig_out <= sig_next;
                end
            end
        end
    end
endmodule

// File: tb/tb_out_xor_signature.sv
// Bench for out_xor_signature: default instance plus an 8-channel, 64-bit, 4-bit-counter instance,
// streamed words checked by queue-based monitors, run signatures checked directly.
module tb_out_xor_signature;
    logic          clk = 1'b0;
    logic          ap_rst_n = 1'b0;
    logic [31:0]   cyc = '0;
    int            total = 0;
    int            bad = 0;

    logic          ap_start = 1'b0, ap_done = 1'b0;
    logic [3:0]    ch_write = '0;
    logic [127:0]  ch_din = '0;
    logic [3:0]    data_out;
    logic          data_valid, sig_valid, busy;
    logic [31:0]   sig_out;
    logic [23:0]   word_cnt;

    logic          ap_start2 = 1'b0, ap_done2 = 1'b0;
    logic [7:0]    ch_write2 = '0;
    logic [511:0]  ch_din2 = '0;
    logic [3:0]    data_out2;
    logic          data_valid2, sig_valid2, busy2;
    logic [31:0]   sig_out2;
    logic [3:0]    word_cnt2;

    logic [35:0]   exp_q[$];
    logic [35:0]   exp_q2[$];

    out_xor_signature dut (
        .ap_clk(clk), .ap_rst_n(ap_rst_n), .ap_start(ap_start), .ap_done(ap_done),
        .ch_write(ch_write), .ch_din(ch_din), .data_out(data_out), .data_valid(data_valid),
        .sig_out(sig_out), .word_cnt(word_cnt), .sig_valid(sig_valid), .busy(busy)
    );

    out_xor_signature #(.CH_NUM(8), .DIN_WIDTH(64), .DOUT_WIDTH(4), .SIG_WIDTH(32), .CNT_WIDTH(4)) dut2 (
        .ap_clk(clk), .ap_rst_n(ap_rst_n), .ap_start(ap_start2), .ap_done(ap_done2),
        .ch_write(ch_write2), .ch_din(ch_din2), .data_out(data_out2), .data_valid(data_valid2),
        .sig_out(sig_out2), .word_cnt(word_cnt2), .sig_valid(sig_valid2), .busy(busy2)
    );

    // clock / reset
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 32'd1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // drivers
    task automatic wr(input logic [3:0] we, input logic [127:0] din, input logic push, input logic [3:0] ev);
        ch_write = we;
        ch_din   = din;
        if (push) exp_q.push_back({cyc + 32'd4, ev});
        tick();
        ch_write = '0;
        ch_din   = '0;
    endtask

    task automatic wr2(input logic [7:0] we, input logic [511:0] din, input logic [3:0] ev);
        ch_write2 = we;
        ch_din2   = din;
        exp_q2.push_back({cyc + 32'd5, ev});
        tick();
        ch_write2 = '0;
        ch_din2   = '0;
    endtask

    task automatic wait_sig(input logic which, output logic [31:0] at);
        at = 32'hFFFF_FFFF;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if ((which == 1'b0 && sig_valid) || (which == 1'b1 && sig_valid2)) begin
                at = cyc;
                break;
            end
        end
    endtask

    // scoreboard monitors
    always @(negedge clk) begin
        if (data_valid) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL stream0_unexpected: got %0h expected none", data_out);
            end else begin
                logic [35:0] e;
                e = exp_q.pop_front();
                check("stream0_data", 64'(data_out), 64'(e[3:0]));
                check("stream0_cycle", 64'(cyc), 64'(e[35:4]));
            end
        end
    end

    always @(negedge clk) begin
        if (data_valid2) begin
            if (exp_q2.size() == 0) begin
                total++;
                bad++;
                $display("FAIL stream1_unexpected: got %0h expected none", data_out2);
            end else begin
                logic [35:0] e;
                e = exp_q2.pop_front();
                check("stream1_data", 64'(data_out2), 64'(e[3:0]));
                check("stream1_cycle", 64'(cyc), 64'(e[35:4]));
            end
        end
    end

    initial begin
        logic [31:0]  at;
        logic [31:0]  d_drive;
        logic [511:0] d2;
        int           sv_seen;

        repeat (3) tick();
        check("reset_data_out", 64'(data_out), 64'h0);
        check("reset_data_valid", 64'(data_valid), 64'h0);
        check("reset_sig_out", 64'(sig_out), 64'h0);
        check("reset_word_cnt", 64'(word_cnt), 64'h0);
        check("reset_busy", 64'(busy), 64'h0);
        ap_rst_n = 1'b1;
        tick();

        // streaming outside a run
        wr(4'b0001, {96'h0, 32'h12345678}, 1'b1, 4'h8);
        repeat (6) tick();
        check("idle_sig_stays_0", 64'(sig_out), 64'h0);
        wr(4'b0101, {32'h0, 32'h12345678, 32'h0, 32'h12345678}, 1'b1, 4'h0);
        wr(4'b1000, {32'h000000F0, 96'h0}, 1'b1, 4'hF);
        wr(4'b1011, {32'h00000400, 32'h0, 32'h00000020, 32'h00000001}, 1'b1, 4'h7);
        repeat (6) tick();

        // run 1: two tagged words, ap_done three cycles after the second
        ap_start = 1'b1;
        tick();
        check("run1_busy", 64'(busy), 64'h1);
        wr(4'b0001, {96'h0, 32'h12345678}, 1'b1, 4'h8);
        wr(4'b0010, {64'h0, 32'h00000001, 32'h0}, 1'b1, 4'h1);
        repeat (2) tick();
        d_drive = cyc;
        ap_done = 1'b1;
        tick();
        ap_done  = 1'b0;
        ap_start = 1'b0;
        wait_sig(1'b0, at);
        check("run1_sig_cycle", 64'(at), 64'(d_drive + 32'd6));
        check("run1_sig_out", 64'(sig_out), 64'h11);
        check("run1_word_cnt", 64'(word_cnt), 64'h2);
        check("run1_busy_low", 64'(busy), 64'h0);
        tick();
        check("run1_sig_pulse", 64'(sig_valid), 64'h0);
        check("run1_sig_held", 64'(sig_out), 64'h11);
        repeat (2) tick();

        // run 2 from REPORT: write on the done cycle counts, the one after does not
        ap_start = 1'b1;
        tick();
        check("run2_clear_sig", 64'(sig_out), 64'h0);
        check("run2_clear_cnt", 64'(word_cnt), 64'h0);
        wr(4'b0100, {32'h0, 32'h000000A0, 64'h0}, 1'b1, 4'hA);
        d_drive = cyc;
        ap_done = 1'b1;
        wr(4'b0010, {64'h0, 32'h00000006, 32'h0}, 1'b1, 4'h6);
        ap_done = 1'b0;
        wr(4'b1000, {32'h00000003, 96'h0}, 1'b1, 4'h3);
        ap_start = 1'b0;
        wait_sig(1'b0, at);
        check("run2_sig_cycle", 64'(at), 64'(d_drive + 32'd6));
        check("run2_sig_out", 64'(sig_out), 64'h12);
        check("run2_word_cnt", 64'(word_cnt), 64'h2);
        repeat (4) tick();

        // run 3: reset pulse during DRAIN aborts the run
        ap_start = 1'b1;
        tick();
        ap_start = 1'b0;
        wr(4'b0001, {96'h0, 32'h000000FF}, 1'b0, 4'h0);
        ap_done = 1'b1;
        tick();
        ap_done  = 1'b0;
        check("run3_busy_drain", 64'(busy), 64'h1);
        ap_rst_n = 1'b0;
        tick();
        ap_rst_n = 1'b1;
        check("rst_data_out", 64'(data_out), 64'h0);
        check("rst_data_valid", 64'(data_valid), 64'h0);
        check("rst_sig_out", 64'(sig_out), 64'h0);
        check("rst_word_cnt", 64'(word_cnt), 64'h0);
        check("rst_sig_valid", 64'(sig_valid), 64'h0);
        check("rst_busy", 64'(busy), 64'h0);
        sv_seen = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (sig_valid) sv_seen++;
        end
        check("rst_no_sig_valid", 64'(sv_seen), 64'h0);
        tick();

        // 8-channel, 64-bit instance: latency 5 and counter saturation
        d2 = '0;
        d2[5*64 +: 64] = 64'h0000000000000003;
        wr2(8'b0010_0000, d2, 4'h3);
        repeat (3) tick();
        ap_start2 = 1'b1;
        tick();
        ap_start2 = 1'b0;
        d2 = '0;
        d2[63:0] = 64'h1;
        for (int k = 0; k < 20; k++) wr2(8'b0000_0001, d2, 4'h1);
        d_drive  = cyc;
        ap_done2 = 1'b1;
        tick();
        ap_done2 = 1'b0;
        wait_sig(1'b1, at);
        check("sat_sig_cycle", 64'(at), 64'(d_drive + 32'd7));
        check("sat_word_cnt", 64'(word_cnt2), 64'hF);
        check("sat_sig_out", 64'(sig_out2), 64'h000F_FFFF);
        repeat (2) tick();
        ap_start2 = 1'b1;
        tick();
        ap_start2 = 1'b0;
        check("sat_restart_cnt", 64'(word_cnt2), 64'h0);
        check("sat_restart_sig", 64'(sig_out2), 64'h0);
        ap_done2 = 1'b1;
        tick();
        ap_done2 = 1'b0;
        repeat (10) tick();

        check("stream0_drained", 64'(exp_q.size()), 64'h0);
        check("stream1_drained", 64'(exp_q2.size()), 64'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/out_xor_signature.md
Name: out_xor_signature

Overview:
- Parametrised output-compaction block between an HLS kernel's FIFO-style output channels (din/write, full_n tied high) and the board-level data_out pins.
- Generalises the fixed 4-channel, 32-to-4-bit XOR reduction to CH_NUM channels and arbitrary widths, with the same select/xor tree.
- Adds a per-run signature: a rotating-XOR accumulator plus a saturating word counter. Both are bounded by ap_start/ap_done and reported once the pipeline has drained.
- Keeps power-measurement runs observable with few pins.

Parameters:
- CH_NUM, 4: number of output channels; power of 2, ≥2.
- DIN_WIDTH, 32: width of each channel word; must be a multiple of DOUT_WIDTH.
- DOUT_WIDTH, 4: width of the compacted streaming output.
- SIG_WIDTH, 32: signature register width; ≥ DOUT_WIDTH.
- CNT_WIDTH, 24: word counter width.

Ports:
- ap_clk  in  1  sole clock, rising edge.
- ap_rst_n  in  1  synchronous active-low reset.
- ap_start  in  1  kernel start level; a run begins on its rising edge.
- ap_done  in  1  kernel done pulse; ends a run.
- ch_write  in  CH_NUM  per-channel write strobe; bit i pairs with ch_din slice i.
- ch_din  in  CH_NUM*DIN_WIDTH  channel words; channel i at [i*DIN_WIDTH +: DIN_WIDTH].
- data_out  out  DOUT_WIDTH  compacted stream word.
- data_valid  out  1  data_out valid.
- sig_out  out  SIG_WIDTH  run signature, held until the next run starts.
- word_cnt  out  CNT_WIDTH  channel words accepted in the run, held with sig_out.
- sig_valid  out  1  one-cycle pulse when sig_out and word_cnt are final.
- busy  out  1  high in RUN or DRAIN.

Behaviour:
- Reset: while ap_rst_n=0 at an edge, all pipeline registers, data_out, data_valid, sig_out, word_cnt, sig_valid and busy go to 0; FSM goes to IDLE. Reset mid-run aborts with no sig_valid.
- Stage 1 (fold): per channel, XOR all DIN_WIDTH/DOUT_WIDTH chunks of ch_din into a DOUT_WIDTH value. Register it with valid = ch_write[i] and tag = acc_en.
- Tree stages: log2(CH_NUM) registered 2-to-1 stages. For each pair:
  - valid = va|vb.
  - value = 0 if neither valid, the valid one alone, or a^b if both valid.
  - tag = OR of the tags of the valid inputs.
- Output stage: registered data_out, data_valid and tag.
- Latency L = log2(CH_NUM)+2: a write at edge t appears on data_out at cycle t+L (L=4 at defaults). Throughput is 1 word/cycle per channel with no backpressure.
- Streaming output runs in every FSM state, independent of runs.
- Start detection: registered ap_start; start_edge = ap_start & ~ap_start_q.
- FSM IDLE:
  - On start_edge: clear sig_out and word_cnt to 0, go to RUN.
- FSM RUN:
  - acc_en = 1.
  - word_cnt += popcount(ch_write) each cycle, saturating at 2^CNT_WIDTH-1.
  - When ap_done=1: writes in the same cycle are still counted and tagged; load drain counter with L; go to DRAIN.
- FSM DRAIN:
  - acc_en = 0; new writes are streamed but neither counted nor tagged.
  - Decrement the drain counter each cycle.
  - At 0: pulse sig_valid for one cycle and go to REPORT.
- FSM REPORT:
  - Outputs held.
  - start_edge clears sig_out and word_cnt and goes to RUN in the same cycle.
- start_edge while in RUN or DRAIN is ignored. ap_done while in IDLE or REPORT is ignored.
- Signature update, any state: when output-stage valid and tag are both 1, sig_out <= rotl(sig_out,1) ^ zero_extend(data_out).
- Timing: with ap_done sampled at edge d, sig_valid is high at cycle d+L+1 and sig_out already includes every tagged word.
- ap_start and ap_done in the same RUN cycle: treat as done.
- busy = (state==RUN) | (state==DRAIN).

Test Plan:
- Defaults; single write on ch0, din=0x12345678 -> data_out=4'h8, data_valid=1 for exactly one cycle, 4 cycles after the write; sig_out stays 0.
- Same cycle: ch0=0x12345678 and ch2=0x12345678 -> data_out=4'h0 with data_valid=1. Then ch3 only, din=0x000000F0 -> data_out=4'hF.
- Run: ap_start rises; ch0 writes 0x12345678, next cycle ch1 writes 0x00000001; ap_done 3 cycles later at edge d -> sig_valid pulse at d+5 with sig_out=0x00000011, word_cnt=2; busy falls at the same point.
- Write on the ap_done cycle is counted; a write one cycle after ap_done is streamed on data_out but not counted or accumulated.
- CNT_WIDTH=4 override: 20 single-channel writes in a run -> word_cnt=15 (saturated). A second start_edge -> word_cnt=0 and sig_out=0 on the next cycle.
- Reset pulse (ap_rst_n=0 for 1 cycle) during DRAIN -> all outputs 0 the next cycle, no sig_valid, FSM in IDLE; CH_NUM=8, DIN_WIDTH=64 regression gives L=5.
